// File: rtl/led_seq_ctrl.sv
// LED sequencer: steps a host-written {pattern, dwell} table on a prescaled tick
// and arbitrates the four LEDs against a higher-priority override requester.
module led_seq_ctrl #(
    parameter int unsigned TICK_DIV   = 50000000,
    parameter int unsigned NUM_STEPS  = 8,
    parameter bit          ACTIVE_LOW = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cfg_we,
    input  logic [$clog2(NUM_STEPS)-1:0] cfg_addr,
    input  logic [3:0]                   cfg_pattern,
    input  logic [7:0]                   cfg_dur,
    input  logic                         start,
    input  logic                         stop,
    input  logic                         ovr_req,
    input  logic [3:0]                   ovr_pattern,
    output logic                         ovr_grant,
    output logic [3:0]                   led,
    output logic                         busy,
    output logic [$clog2(NUM_STEPS)-1:0] step_idx,
    output logic                         wrap
);

    localparam int unsigned AW = $clog2(NUM_STEPS);
    localparam int unsigned PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] TickLast = PW'(TICK_DIV - 1);
    localparam logic [AW-1:0] LastStep = AW'(NUM_STEPS - 1);
    localparam logic [3:0]    LedOff   = ACTIVE_LOW ? 4'hF : 4'h0;

    typedef enum logic [1:0] {StIdle, StLoad, StRun} state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] step_q, step_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [7:0]    dwell_q, dwell_d;
    logic [3:0]    cur_pat_q, cur_pat_d;
    logic [7:0]    cur_dur_q, cur_dur_d;
    logic          wrap_q, wrap_d;
    logic          grant_q;
    logic [3:0]    led_q, led_d;
    logic [3:0]    led_pat;

    logic [3:0]    pat_tbl [NUM_STEPS];
    logic [7:0]    dur_tbl [NUM_STEPS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_STEPS; i++) begin
                pat_tbl[i] <= '0;
                dur_tbl[i] <= '0;
            end
        end else if (cfg_we) begin
            pat_tbl[cfg_addr] <= cfg_pattern;
            dur_tbl[cfg_addr] <= cfg_dur;
        end
    end

    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        presc_d   = presc_q;
        dwell_d   = dwell_q;
        cur_pat_d = cur_pat_q;
        cur_dur_d = cur_dur_q;
        wrap_d    = 1'b0;
        if (stop) begin
            state_d   = StIdle;
            step_d    = '0;
            presc_d   = '0;
            dwell_d   = '0;
            cur_pat_d = '0;
        end else if (!grant_q) begin
            // A granted override freezes the whole sequencer in place.
            unique case (state_q)
                StIdle: begin
                    if (start && dur_tbl[0] != 8'd0) state_d = StLoad;
                end
                StLoad: begin
                    presc_d = '0;
                    dwell_d = '0;
                    if (dur_tbl[step_q] == 8'd0) begin
                        if (step_q == '0) begin
                            state_d   = StIdle;
                            cur_pat_d = '0;
                        end else begin
                            step_d = '0;
                            wrap_d = 1'b1;
                        end
                    end else begin
                        cur_pat_d = pat_tbl[step_q];
                        cur_dur_d = dur_tbl[step_q];
                        state_d   = StRun;
                    end
                end
                StRun: begin
                    if (presc_q == TickLast) begin
                        presc_d = '0;
                        if (dwell_q == cur_dur_q - 8'd1) begin
                            dwell_d = '0;
                            state_d = StLoad;
                            step_d  = step_q + 1'b1;
                            wrap_d  = (step_q == LastStep);
                        end else begin
                            dwell_d = dwell_q + 8'd1;
                        end
                    end else begin
                        presc_d = presc_q + 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
        // cur_pat is held at zero in IDLE, so the sequencer view is "off" there.
        led_pat = ovr_req ? ovr_pattern : cur_pat_d;
        led_d   = ACTIVE_LOW ? ~led_pat : led_pat;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            step_q    <= '0;
            presc_q   <= '0;
            dwell_q   <= '0;
            cur_pat_q <= '0;
            cur_dur_q <= '0;
            wrap_q    <= 1'b0;
            grant_q   <= 1'b0;
            led_q     <= LedOff;
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            presc_q   <= presc_d;
            dwell_q   <= dwell_d;
            cur_pat_q <= cur_pat_d;
            cur_dur_q <= cur_dur_d;
            wrap_q    <= wrap_d;
            grant_q   <= ovr_req;
            led_q     <= led_d;
        end
    end

    assign ovr_grant = grant_q;
    assign led       = led_q;
    assign busy      = (state_q != StIdle);
    assign step_idx  = step_q;
    assign wrap      = wrap_q;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Bench for led_seq_ctrl: directed scenarios plus random traffic, scored per cycle
// against a step-level reference model that counts remaining dwell cycles directly.
module tb_led_seq_ctrl;

    localparam int unsigned TICK_DIV  = 4;
    localparam int unsigned NUM_STEPS = 8;
    localparam int unsigned AW        = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cfg_we = 1'b0;
    logic [AW-1:0] cfg_addr = '0;
    logic [3:0]    cfg_pattern = '0;
    logic [7:0]    cfg_dur = '0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          ovr_req = 1'b0;
    logic [3:0]    ovr_pattern = '0;
    logic          ovr_grant;
    logic [3:0]    led;
    logic          busy;
    logic [AW-1:0] step_idx;
    logic          wrap;

    led_seq_ctrl #(
        .TICK_DIV  (TICK_DIV),
        .NUM_STEPS (NUM_STEPS),
        .ACTIVE_LOW(1'b1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_pattern(cfg_pattern),
        .cfg_dur    (cfg_dur),
        .start      (start),
        .stop       (stop),
        .ovr_req    (ovr_req),
        .ovr_pattern(ovr_pattern),
        .ovr_grant  (ovr_grant),
        .led        (led),
        .busy       (busy),
        .step_idx   (step_idx),
        .wrap       (wrap)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]    led;
        logic          busy;
        logic [AW-1:0] step;
        logic          wrap;
        logic          grant;
    } obs_t;

    obs_t exp_q[$];
    obs_t mon_e, mon_a;
    int   checks = 0;
    int   errors = 0;

    // Reference model: table, phase, and cycles left in the current dwell.
    typedef enum {MIdle, MLoad, MRun} mode_e;
    logic [3:0] m_tpat [NUM_STEPS];
    logic [7:0] m_tdur [NUM_STEPS];
    mode_e      m_mode;
    int         m_step;
    int         m_left;
    logic [3:0] m_pat;
    logic       m_grant;
    logic       m_wrap;
    logic [3:0] m_led;

    task automatic model_edge();
        if (rst) begin
            for (int i = 0; i < NUM_STEPS; i++) begin
                m_tpat[i] = '0;
                m_tdur[i] = '0;
            end
            m_mode = MIdle; m_step = 0; m_left = 0; m_pat = '0;
            m_grant = 1'b0; m_wrap = 1'b0; m_led = 4'hF;
        end else begin
            m_wrap = 1'b0;
            if (stop) begin
                m_mode = MIdle; m_step = 0; m_pat = '0;
            end else if (!m_grant) begin
                case (m_mode)
                    MIdle: if (start && m_tdur[0] != 0) m_mode = MLoad;
                    MLoad: begin
                        if (m_tdur[m_step] == 0) begin
                            if (m_step == 0) begin
                                m_mode = MIdle; m_pat = '0;
                            end else begin
                                m_step = 0; m_wrap = 1'b1;
                            end
                        end else begin
                            m_pat  = m_tpat[m_step];
                            m_left = int'(m_tdur[m_step]) * TICK_DIV;
                            m_mode = MRun;
                        end
                    end
                    default: begin
                        m_left--;
                        if (m_left == 0) begin
                            m_step = (m_step + 1) % NUM_STEPS;
                            m_wrap = (m_step == 0);
                            m_mode = MLoad;
                        end
                    end
                endcase
            end
            if (cfg_we) begin
                m_tpat[cfg_addr] = cfg_pattern;
                m_tdur[cfg_addr] = cfg_dur;
            end
            m_grant = ovr_req;
            m_led   = ~(ovr_req ? ovr_pattern : m_pat);
        end
    endtask

    task automatic tick();
        obs_t e;
        @(posedge clk);
        model_edge();
        e.led   = m_led;
        e.busy  = (m_mode != MIdle);
        e.step  = AW'(m_step);
        e.wrap  = m_wrap;
        e.grant = m_grant;
        exp_q.push_back(e);
        #1;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            mon_a = '{led: led, busy: busy, step: step_idx, wrap: wrap, grant: ovr_grant};
            checks++;
            if (mon_a !== mon_e) begin
                errors++;
                $display("FAIL cycle_obs t=%0t got led=%h busy=%b step=%0d wrap=%b grant=%b want led=%h busy=%b step=%0d wrap=%b grant=%b",
                         $time, mon_a.led, mon_a.busy, mon_a.step, mon_a.wrap, mon_a.grant,
                         mon_e.led, mon_e.busy, mon_e.step, mon_e.wrap, mon_e.grant);
            end
        end
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wr(input int a, input logic [3:0] p, input logic [7:0] d);
        cfg_we = 1'b1; cfg_addr = AW'(a); cfg_pattern = p; cfg_dur = d;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic hit_reset(input string where);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check({where, "_led"}, 8'(led), 8'hF);
        check({where, "_grant"}, 8'(ovr_grant), 8'h0);
        check({where, "_busy"}, 8'(busy), 8'h0);
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int wraps;
        run(3);
        rst = 1'b0;
        tick();

        // Two-step sequence terminated by a zero-dwell marker.
        wr(0, 4'b0001, 8'd1);
        wr(1, 4'b0010, 8'd2);
        wr(2, 4'b0000, 8'd0);
        pulse_start();
        tick();
        check("seq_step0_led", 8'(led), 8'hE);
        run(40);
        stop = 1'b1; tick(); stop = 1'b0;
        check("stop_busy", 8'(busy), 8'h0);
        check("stop_led", 8'(led), 8'hF);

        // Override mid-dwell must push the step change out by exactly 10 cycles.
        wr(0, 4'b0001, 8'd2);
        wr(1, 4'b0010, 8'd1);
        ovr_pattern = 4'b1010;
        pulse_start();
        n = 0;
        while (n < 40 && step_idx != 3'd1) begin
            if (n == 3) ovr_req = 1'b1;
            if (n == 13) ovr_req = 1'b0;
            tick();
            n++;
            if (n == 5) check("ovr_led", 8'(led), 8'h5);
        end
        check("ovr_dwell_cycles", 8'(n), 8'd19);
        run(12);

        // Rewrite the active step's pattern while it runs.
        wr(m_step, 4'b1111, m_tdur[m_step]);
        run(30);

        start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
        check("startstop_busy", 8'(busy), 8'h0);
        check("startstop_step", 8'(step_idx), 8'h0);
        check("startstop_led", 8'(led), 8'hF);

        wr(0, 4'h3, 8'd0);
        pulse_start();
        run(3);
        check("dur0_busy", 8'(busy), 8'h0);
        check("dur0_led", 8'(led), 8'hF);

        // Full table of one-tick steps: one wrap per 40 cycles.
        for (int a = 0; a < NUM_STEPS; a++) wr(a, 4'(a + 1), 8'd1);
        pulse_start();
        run(10);
        wraps = 0;
        for (int i = 0; i < 80; i++) begin
            tick();
            if (wrap) wraps++;
        end
        check("wrap_per_80", 8'(wraps), 8'd2);

        hit_reset("rst_run");
        pulse_start();
        run(3);
        check("rst_table_cleared", 8'(busy), 8'h0);

        wr(0, 4'b0100, 8'd1);
        pulse_start();
        run(3);
        ovr_pattern = 4'b0110;
        ovr_req = 1'b1;
        run(3);
        hit_reset("rst_ovr");
        ovr_req = 1'b0;
        tick();

        for (int i = 0; i < 800; i++) begin
            cfg_we      = ($urandom_range(0, 3) == 0);
            cfg_addr    = AW'($urandom_range(0, NUM_STEPS - 1));
            cfg_pattern = 4'($urandom);
            cfg_dur     = ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom_range(1, 3));
            start       = ($urandom_range(0, 9) == 0);
            stop        = ($urandom_range(0, 79) == 0);
            if ($urandom_range(0, 24) == 0) ovr_req = ~ovr_req;
            ovr_pattern = 4'($urandom);
            tick();
        end
        cfg_we = 1'b0; start = 1'b0; stop = 1'b0; ovr_req = 1'b0;
        run(4);

        n = 0;
        while (exp_q.size() != 0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        #1;
        check("queue_drained", 8'(exp_q.size()), 8'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/led_seq_ctrl.md
Name: led_seq_ctrl

Overview:
Programmable sequencer and arbiter for the board's 4 user LEDs. It steps through a small host-written table of {pattern, dwell} entries using a prescaled tick, so new LED sequences need no new RTL. It also arbitrates the LEDs between the sequencer and a higher-priority override requester, such as an error or status source. It sits between the host/config logic and the LED pins.

Parameters:
TICK_DIV, 50000000, clk cycles per dwell tick (1 s at 50 MHz); legal range >= 2.
NUM_STEPS, 8, table depth; power of 2, max 16.
ACTIVE_LOW, 1, 1: LED pin driven low = lit; 0: active-high.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
cfg_we  in  1  table write strobe, one entry per cycle
cfg_addr  in  log2(NUM_STEPS)  table entry index
cfg_pattern  in  4  LED pattern, 1 = lit, bit0 = LED0
cfg_dur  in  8  dwell in ticks; 0 = end-of-sequence marker
start  in  1  level-sampled run request
stop  in  1  level-sampled halt request
ovr_req  in  1  override request, held high for the whole ownership period
ovr_pattern  in  4  override pattern, 1 = lit
ovr_grant  out  1  override owns the LEDs
led  out  4  LED pins, registered
busy  out  1  sequencer not IDLE
step_idx  out  log2(NUM_STEPS)  current step
wrap  out  1  one-cycle pulse on wrap to step 0

Behaviour:
- Reset values: all table entries {0,0}; state IDLE; step_idx 0; prescaler 0; dwell counter 0; busy 0; wrap 0; ovr_grant 0; led all-off (4'hF if ACTIVE_LOW, else 4'h0).
- Table writes are synchronous and accepted in any state. A write to the active step does not affect the latched copy; it takes effect at that step's next LOAD.
- States: IDLE, LOAD, RUN.
- IDLE:
  - start=1 and stop=0 and entry0.dur != 0 -> LOAD.
  - start with entry0.dur == 0 is ignored; the block stays IDLE.
- LOAD (exactly 1 cycle):
  - Latch pattern/dur of step_idx; clear prescaler and dwell counter.
  - If latched dur == 0: step_idx <= 0, pulse wrap, stay in LOAD (re-load entry 0). Entry0.dur == 0 here -> IDLE instead.
  - Otherwise -> RUN.
- RUN:
  - Prescaler counts 0..TICK_DIV-1; tick is asserted when it equals TICK_DIV-1 (prescaler then wraps to 0).
  - On tick, dwell counter increments. When dwell == dur-1 at a tick, step_idx advances -> LOAD.
  - If step_idx == NUM_STEPS-1, the advance wraps step_idx to 0 and pulses wrap in the same cycle step_idx becomes 0.
- Step timing: each step occupies dur*TICK_DIV RUN cycles plus 1 LOAD cycle. led changes on the clock edge that leaves LOAD.
- stop=1 in any state -> IDLE next edge, step_idx 0, led off. stop and start asserted together: stop wins. start while busy is ignored.
- Override:
  - ovr_grant registers ovr_req (1-cycle latency, both edges).
  - While ovr_grant=1: led = ovr_pattern (registered, same edge as grant), prescaler and dwell counter frozen, LOAD transitions stalled. The state resumes exactly where it froze after release.
  - On release, led returns to the latched sequencer pattern (or off if IDLE) on the edge that deasserts ovr_grant.
  - Override works in IDLE too. stop during override takes effect immediately on the sequencer state; led stays override-owned.
- Output polarity: led = ACTIVE_LOW ? ~pat : pat, where pat is the 1=lit pattern.
- busy = (state != IDLE).
- rst mid-operation: all state returns to reset values asynchronously, including the table.

Test Plan:
- TICK_DIV=4. Write e0={4'b0001,1}, e1={4'b0010,2}, e2={0,0}; start pulse -> led (active-low) 4'hE for 4 cycles, LOAD 1 cycle, then 4'hD for 8 cycles, LOAD, then wrap pulse with step_idx=0 and 4'hE again.
- All 8 entries dur=1 -> step_idx 0..7 then 0; wrap asserted exactly once per 8*(4+1)=40 cycles.
- ovr_req held 10 cycles mid-step with ovr_pattern=4'b1010 -> one cycle later ovr_grant=1 and led=4'h5. After release, the sequencer finishes its remaining dwell cycles unchanged (cycle-count check).
- Entry0.dur=0 with start=1 -> busy stays 0, led 4'hF. start=stop=1 while running -> IDLE, led 4'hF, step_idx 0.
- Rewrite the active step's pattern during RUN -> led unchanged until that step is next loaded.
- Assert rst during RUN and during override -> immediate led 4'hF, ovr_grant 0, busy 0; table reads back as all-zero (next start is ignored).
